// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Dual-issue instruction fetch stage with stall, redirect and
//            end-of-program (all-zero word) detection.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [31:0]     NOP      = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic [PC_W-1:0] imem_addr1,
    output logic [PC_W-1:0] imem_addr2,
    input  logic [31:0]     imem_data1,
    input  logic [31:0]     imem_data2,
    output logic [PC_W-1:0] PC1,
    output logic [PC_W-1:0] PC2,
    output logic [31:0]     instr1,
    output logic [31:0]     instr2,
    output logic            start,
    output logic            done,
    output logic [7:0]      pairs_fetched
);

    localparam logic [PC_W-1:0] c_four  = PC_W'(4);
    localparam logic [PC_W-1:0] c_eight = PC_W'(8);
    localparam logic [7:0]      c_cnt_max = 8'hFF;

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [PC_W-1:0] r_pc, w_pc_nxt;
    logic [PC_W-1:0] r_pc1, w_pc1_nxt;
    logic [PC_W-1:0] r_pc2, w_pc2_nxt;
    logic [31:0]     r_instr1, w_instr1_nxt;
    logic [31:0]     r_instr2, w_instr2_nxt;
    logic            r_start, w_start_nxt;
    logic            r_done, w_done_nxt;
    logic [7:0]      r_cnt, w_cnt_nxt;
    logic [PC_W-1:0] w_pc_plus4;

    // Addresses come only from the PC register, never from stall/redirect.
    assign w_pc_plus4 = r_pc + c_four;
    assign imem_addr1 = r_pc;
    assign imem_addr2 = w_pc_plus4;

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_pc1_nxt    = r_pc1;
        w_pc2_nxt    = r_pc2;
        w_instr1_nxt = r_instr1;
        w_instr2_nxt = r_instr2;
        w_start_nxt  = r_start;
        w_done_nxt   = r_done;
        w_cnt_nxt    = r_cnt;

        if (redirect) begin
            w_pc_nxt    = {redirect_pc[PC_W-1:2], 2'b00};
            w_start_nxt = 1'b0;
            w_done_nxt  = 1'b0;
            w_state_nxt = ST_FETCH;
        end else if (!stall) begin
            case (r_state)
                ST_FETCH: begin
                    if (imem_data1 != 32'h0) begin
                        w_pc1_nxt    = r_pc;
                        w_pc2_nxt    = w_pc_plus4;
                        w_instr1_nxt = imem_data1;
                        w_start_nxt  = 1'b1;
                        if (r_cnt != c_cnt_max) begin
                            w_cnt_nxt = r_cnt + 8'd1;
                        end
                        if (imem_data2 != 32'h0) begin
                            w_instr2_nxt = imem_data2;
                            w_pc_nxt     = r_pc + c_eight;
                        end else begin
                            // Terminator in slot 2: issue slot 1 padded with NOP.
                            w_instr2_nxt = NOP;
                            w_state_nxt  = ST_DONE;
                            w_done_nxt   = 1'b1;
                        end
                    end else begin
                        w_start_nxt = 1'b0;
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                    end
                end
                ST_DONE: begin
                    w_start_nxt = 1'b0;
                    w_done_nxt  = 1'b1;
                end
                default: begin
                    w_state_nxt = ST_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_FETCH;
            r_pc     <= RESET_PC;
            r_pc1    <= '0;
            r_pc2    <= '0;
            r_instr1 <= '0;
            r_instr2 <= '0;
            r_start  <= 1'b0;
            r_done   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_pc1    <= w_pc1_nxt;
            r_pc2    <= w_pc2_nxt;
            r_instr1 <= w_instr1_nxt;
            r_instr2 <= w_instr2_nxt;
            r_start  <= w_start_nxt;
            r_done   <= w_done_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign PC1           = r_pc1;
    assign PC2           = r_pc2;
    assign instr1        = r_instr1;
    assign instr2        = r_instr2;
    assign start         = r_start;
    assign done          = r_done;
    assign pairs_fetched = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Directed self-checking bench for fetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_pc = 8'h00;
    logic [7:0]  imem_addr1, imem_addr2;
    logic [31:0] imem_data1, imem_data2;
    logic [7:0]  PC1, PC2;
    logic [31:0] instr1, instr2;
    logic        start, done;
    logic [7:0]  pairs_fetched;

    logic [31:0] mem [0:63];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    assign imem_data1 = mem[imem_addr1[7:2]];
    assign imem_data2 = mem[imem_addr2[7:2]];

    fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .imem_addr1    (imem_addr1),
        .imem_addr2    (imem_addr2),
        .imem_data1    (imem_data1),
        .imem_data2    (imem_data2),
        .PC1           (PC1),
        .PC2           (PC2),
        .instr1        (instr1),
        .instr2        (instr2),
        .start         (start),
        .done          (done),
        .pairs_fetched (pairs_fetched)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fill_all();
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | 32'(i + 1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".PC1"}, 32'(PC1), 32'h0);
        chk({tag, ".PC2"}, 32'(PC2), 32'h0);
        chk({tag, ".instr1"}, instr1, 32'h0);
        chk({tag, ".instr2"}, instr2, 32'h0);
        chk({tag, ".start"}, 32'(start), 32'h0);
        chk({tag, ".done"}, 32'(done), 32'h0);
        chk({tag, ".cnt"}, 32'(pairs_fetched), 32'h0);
        chk({tag, ".addr1"}, 32'(imem_addr1), 32'h0);
        chk({tag, ".addr2"}, 32'(imem_addr2), 32'h4);
    endtask

    initial begin
        // ---------------- straight-line fetch ----------------
        fill_all();
        mem[6] = 32'h0;
        rst = 1'b1;
        step();
        chk_reset("rst0");
        rst = 1'b0;
        step();
        chk("sl.p0.start", 32'(start), 32'h1);
        chk("sl.p0.PC1", 32'(PC1), 32'h00);
        chk("sl.p0.PC2", 32'(PC2), 32'h04);
        chk("sl.p0.i1", instr1, 32'hA000_0001);
        chk("sl.p0.i2", instr2, 32'hA000_0002);
        step();
        chk("sl.p1.PC1", 32'(PC1), 32'h08);
        chk("sl.p1.i2", instr2, 32'hA000_0004);
        chk("sl.p1.start", 32'(start), 32'h1);
        step();
        chk("sl.p2.PC1", 32'(PC1), 32'h10);
        chk("sl.p2.PC2", 32'(PC2), 32'h14);
        chk("sl.p2.i2", instr2, 32'hA000_0006);
        chk("sl.p2.done", 32'(done), 32'h0);
        step();
        chk("sl.end.start", 32'(start), 32'h0);
        chk("sl.end.done", 32'(done), 32'h1);
        chk("sl.end.cnt", 32'(pairs_fetched), 32'd3);
        chk("sl.end.PC1", 32'(PC1), 32'h10);
        step();
        chk("sl.hold.done", 32'(done), 32'h1);
        chk("sl.hold.addr1", 32'(imem_addr1), 32'h18);

        // ---------------- odd tail ----------------
        fill_all();
        mem[3] = 32'h0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("odd.p0.PC1", 32'(PC1), 32'h00);
        step();
        chk("odd.p1.PC1", 32'(PC1), 32'h08);
        chk("odd.p1.PC2", 32'(PC2), 32'h0C);
        chk("odd.p1.i1", instr1, 32'hA000_0003);
        chk("odd.p1.i2", instr2, 32'h0000_0013);
        chk("odd.p1.start", 32'(start), 32'h1);
        chk("odd.p1.done", 32'(done), 32'h1);
        step();
        chk("odd.end.start", 32'(start), 32'h0);
        chk("odd.end.done", 32'(done), 32'h1);
        chk("odd.end.cnt", 32'(pairs_fetched), 32'd2);

        // ---------------- stall ----------------
        fill_all();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        step();
        chk("st.pre.PC1", 32'(PC1), 32'h08);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("st.hold.PC1", 32'(PC1), 32'h08);
            chk("st.hold.i1", instr1, 32'hA000_0003);
            chk("st.hold.start", 32'(start), 32'h1);
            chk("st.hold.addr1", 32'(imem_addr1), 32'h10);
            chk("st.hold.cnt", 32'(pairs_fetched), 32'd2);
        end
        stall = 1'b0;
        step();
        chk("st.next.PC1", 32'(PC1), 32'h10);
        chk("st.next.i1", instr1, 32'hA000_0005);
        chk("st.next.cnt", 32'(pairs_fetched), 32'd3);

        // ---------------- redirect during stall ----------------
        stall = 1'b1;
        redirect = 1'b1;
        redirect_pc = 8'h23;
        step();
        chk("rd.sq.start", 32'(start), 32'h0);
        chk("rd.sq.addr1", 32'(imem_addr1), 32'h20);
        chk("rd.sq.addr2", 32'(imem_addr2), 32'h24);
        chk("rd.sq.cnt", 32'(pairs_fetched), 32'd3);
        stall = 1'b0;
        redirect = 1'b0;
        step();
        chk("rd.p.PC1", 32'(PC1), 32'h20);
        chk("rd.p.PC2", 32'(PC2), 32'h24);
        chk("rd.p.i1", instr1, 32'hA000_0009);
        chk("rd.p.start", 32'(start), 32'h1);
        chk("rd.p.cnt", 32'(pairs_fetched), 32'd4);

        // ---------------- redirect out of DONE with wrap ----------------
        mem[10] = 32'h0;
        step();
        chk("dn.start", 32'(start), 32'h0);
        chk("dn.done", 32'(done), 32'h1);
        step();
        chk("dn.stay", 32'(done), 32'h1);
        fill_all();
        redirect = 1'b1;
        redirect_pc = 8'hFC;
        step();
        redirect = 1'b0;
        chk("wr.done", 32'(done), 32'h0);
        chk("wr.start", 32'(start), 32'h0);
        chk("wr.addr1", 32'(imem_addr1), 32'hFC);
        chk("wr.addr2", 32'(imem_addr2), 32'h00);
        step();
        chk("wr.p.PC1", 32'(PC1), 32'hFC);
        chk("wr.p.PC2", 32'(PC2), 32'h00);
        chk("wr.p.i1", instr1, 32'hA000_0040);
        chk("wr.p.i2", instr2, 32'hA000_0001);
        chk("wr.p.start", 32'(start), 32'h1);
        step();
        chk("wr.n.PC1", 32'(PC1), 32'h04);
        chk("wr.n.cnt", 32'(pairs_fetched), 32'd6);

        // ---------------- reset mid-run with redirect and stall high ----------------
        rst = 1'b1;
        redirect = 1'b1;
        stall = 1'b1;
        redirect_pc = 8'h40;
        step();
        chk_reset("rst1");
        rst = 1'b0;
        redirect = 1'b0;
        stall = 1'b0;
        step();
        chk("rr.PC1", 32'(PC1), 32'h00);
        chk("rr.start", 32'(start), 32'h1);
        chk("rr.cnt", 32'(pairs_fetched), 32'd1);

        // ---------------- counter saturation ----------------
        for (int i = 0; i < 253; i++) step();
        chk("sat.254", 32'(pairs_fetched), 32'd254);
        step();
        chk("sat.255", 32'(pairs_fetched), 32'd255);
        for (int i = 0; i < 46; i++) step();
        chk("sat.hold", 32'(pairs_fetched), 32'd255);
        chk("sat.start", 32'(start), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
